// File: rtl/eep_arb_pkg.sv
// Shared types and constants for the EEPROM arbiter.
// EEP_WR_VERIFY_EN adds the write read-back states to the state enum.
package eep_arb_pkg;

  localparam int EEP_AW = 2;
  localparam int EEP_DW = 14;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_CAP,
    ST_WR_SETUP,
    ST_WR_CHRG,
    ST_WR_HOLD,
`ifdef EEP_WR_VERIFY_EN
    ST_VFY_RD,
    ST_VFY_CAP,
`endif
    ST_DONE
  } state_e;

  localparam logic OWNER_PID  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  // EEPROM pin values whenever no access is in flight
  localparam logic              EEP_CS_N_IDLE  = 1'b1;
  localparam logic              EEP_R_W_N_IDLE = 1'b1;
  localparam logic [EEP_AW-1:0] EEP_ADDR_IDLE  = 2'd0;
  localparam logic [EEP_DW-1:0] EEP_DATA_IDLE  = 14'd0;

  // Coefficient slots inside the 4-entry array
  localparam logic [EEP_AW-1:0] ADDR_KP  = 2'd0;
  localparam logic [EEP_AW-1:0] ADDR_KI  = 2'd1;
  localparam logic [EEP_AW-1:0] ADDR_KD  = 2'd2;
  localparam logic [EEP_AW-1:0] ADDR_CFG = 2'd3;

endpackage

// File: rtl/eep_arbiter_chrg_timer.sv
// Charge-pump down-counter: load a start value, count to zero, flag zero.
module chrg_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/eep_arbiter.sv
// Shares the 4x14 EEPROM between the PID coefficient fetch and the host config path.
// Optional EEP_WR_VERIFY_EN: read back after each write and flag mismatches on wr_err.
module eep_arbiter
  import eep_arb_pkg::*;
#(
  parameter int CHRG_CYCLES = 150000,
  parameter int CNT_W       = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pid_req,
  input  logic [1:0]  pid_addr,
  output logic        pid_gnt,
  output logic        pid_done,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [1:0]  host_addr,
  input  logic [13:0] host_wr_data,
  output logic        host_gnt,
  output logic        host_done,
  output logic [13:0] rd_data,
  output logic        busy,
  input  logic [13:0] eep_rd_data,
  output logic        eep_cs_n,
  output logic        eep_r_w_n,
  output logic [1:0]  eep_addr,
  output logic [13:0] eep_wr_data,
  output logic        chrg_pmp_en
`ifdef EEP_WR_VERIFY_EN
  ,
  output logic        wr_err
`endif
);

  localparam logic [CNT_W-1:0] CHRG_LOAD = CNT_W'(CHRG_CYCLES - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        op_wr_q, op_wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [13:0] wdata_q, wdata_d;
  logic [13:0] rd_data_q, rd_data_d;
  logic        pid_gnt_q, pid_gnt_d, host_gnt_q, host_gnt_d;
  logic        pid_done_q, pid_done_d, host_done_q, host_done_d;
  logic        busy_q, busy_d;
  logic        cs_n_q, cs_n_d, r_w_n_q, r_w_n_d, pmp_q, pmp_d;
  logic [1:0]  eaddr_q, eaddr_d;
  logic [13:0] ewdata_q, ewdata_d;
`ifdef EEP_WR_VERIFY_EN
  logic        wr_err_q, wr_err_d;
`endif
  logic        grant, tmr_load, tmr_en, tmr_zero;

  chrg_timer #(.CNT_W(CNT_W)) u_chrg_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (CHRG_LOAD),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
`ifdef EEP_WR_VERIFY_EN
    wr_err_d     = wr_err_q;
`endif
    grant        = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pid_req || host_req) begin
          grant = 1'b1;
          // Contention goes to whoever did not own the previous op
          if (pid_req && host_req) owner_d = ~last_owner_q;
          else                     owner_d = host_req ? OWNER_HOST : OWNER_PID;
          last_owner_d = owner_d;
          if (owner_d == OWNER_HOST) begin
            op_wr_d = host_wr;
            addr_d  = host_addr;
            wdata_d = host_wr_data;
          end else begin
            op_wr_d = 1'b0;
            addr_d  = pid_addr;
            wdata_d = EEP_DATA_IDLE;
          end
`ifdef EEP_WR_VERIFY_EN
          if (owner_d == OWNER_HOST && host_wr) wr_err_d = 1'b0;
`endif
          state_d = op_wr_d ? ST_WR_SETUP : ST_RD;
        end
      end
      ST_RD:     state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rd_data_d = eep_rd_data;
        state_d   = ST_DONE;
      end
      ST_WR_SETUP: begin
        tmr_load = 1'b1;
        state_d  = ST_WR_CHRG;
      end
      ST_WR_CHRG: begin
        if (tmr_zero) state_d = ST_WR_HOLD;
        else          tmr_en  = 1'b1;
      end
`ifdef EEP_WR_VERIFY_EN
      ST_WR_HOLD: state_d = ST_VFY_RD;
      ST_VFY_RD:  state_d = ST_VFY_CAP;
      ST_VFY_CAP: begin
        rd_data_d = eep_rd_data;
        wr_err_d  = (eep_rd_data != wdata_q);
        state_d   = ST_DONE;
      end
`else
      ST_WR_HOLD: state_d = ST_DONE;
`endif
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    pid_gnt_d   = grant && (owner_d == OWNER_PID);
    host_gnt_d  = grant && (owner_d == OWNER_HOST);
    pid_done_d  = (state_d == ST_DONE) && (owner_d == OWNER_PID);
    host_done_d = (state_d == ST_DONE) && (owner_d == OWNER_HOST);
    busy_d      = (state_d != ST_IDLE);
    cs_n_d      = EEP_CS_N_IDLE;
    r_w_n_d     = EEP_R_W_N_IDLE;
    eaddr_d     = EEP_ADDR_IDLE;
    ewdata_d    = EEP_DATA_IDLE;
    pmp_d       = 1'b0;

    case (state_d)
      ST_RD, ST_RD_CAP: begin
        cs_n_d  = 1'b0;
        eaddr_d = addr_d;
      end
`ifdef EEP_WR_VERIFY_EN
      ST_VFY_RD, ST_VFY_CAP: begin
        cs_n_d  = 1'b0;
        eaddr_d = addr_d;
      end
`endif
      ST_WR_SETUP, ST_WR_CHRG, ST_WR_HOLD: begin
        cs_n_d   = 1'b0;
        r_w_n_d  = 1'b0;
        eaddr_d  = addr_d;
        ewdata_d = wdata_d;
        pmp_d    = (state_d == ST_WR_CHRG);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_PID;
      last_owner_q <= OWNER_PID;
      op_wr_q      <= 1'b0;
      addr_q       <= EEP_ADDR_IDLE;
      wdata_q      <= EEP_DATA_IDLE;
      rd_data_q    <= '0;
      pid_gnt_q    <= 1'b0;
      host_gnt_q   <= 1'b0;
      pid_done_q   <= 1'b0;
      host_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      cs_n_q       <= EEP_CS_N_IDLE;
      r_w_n_q      <= EEP_R_W_N_IDLE;
      eaddr_q      <= EEP_ADDR_IDLE;
      ewdata_q     <= EEP_DATA_IDLE;
      pmp_q        <= 1'b0;
`ifdef EEP_WR_VERIFY_EN
      wr_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      pid_gnt_q    <= pid_gnt_d;
      host_gnt_q   <= host_gnt_d;
      pid_done_q   <= pid_done_d;
      host_done_q  <= host_done_d;
      busy_q       <= busy_d;
      cs_n_q       <= cs_n_d;
      r_w_n_q      <= r_w_n_d;
      eaddr_q      <= eaddr_d;
      ewdata_q     <= ewdata_d;
      pmp_q        <= pmp_d;
`ifdef EEP_WR_VERIFY_EN
      wr_err_q     <= wr_err_d;
`endif
    end
  end

  assign pid_gnt     = pid_gnt_q;
  assign host_gnt    = host_gnt_q;
  assign pid_done    = pid_done_q;
  assign host_done   = host_done_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign eep_cs_n    = cs_n_q;
  assign eep_r_w_n   = r_w_n_q;
  assign eep_addr    = eaddr_q;
  assign eep_wr_data = ewdata_q;
  assign chrg_pmp_en = pmp_q;
`ifdef EEP_WR_VERIFY_EN
  assign wr_err      = wr_err_q;
`endif

endmodule

// File: tb/tb_eep_arbiter.sv
// Self-checking bench for eep_arbiter: EEPROM model plus transaction-level reference model.
module tb_eep_arbiter;

  localparam int CHRG = 8;
`ifdef EEP_WR_VERIFY_EN
  localparam int VFYX = 2;
`else
  localparam int VFYX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pid_req, host_req, host_wr;
  logic [1:0]  pid_addr, host_addr;
  logic [13:0] host_wr_data;
  logic        pid_gnt, pid_done, host_gnt, host_done, busy;
  logic [13:0] rd_data, eep_rd_data, eep_wr_data;
  logic        eep_cs_n, eep_r_w_n, chrg_pmp_en;
  logic [1:0]  eep_addr;
`ifdef EEP_WR_VERIFY_EN
  logic        wr_err;
`endif

  always #5 clk = ~clk;

  eep_arbiter #(.CHRG_CYCLES(CHRG), .CNT_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .pid_req(pid_req), .pid_addr(pid_addr), .pid_gnt(pid_gnt), .pid_done(pid_done),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_gnt(host_gnt), .host_done(host_done),
    .rd_data(rd_data), .busy(busy), .eep_rd_data(eep_rd_data),
    .eep_cs_n(eep_cs_n), .eep_r_w_n(eep_r_w_n), .eep_addr(eep_addr),
    .eep_wr_data(eep_wr_data), .chrg_pmp_en(chrg_pmp_en)
`ifdef EEP_WR_VERIFY_EN
    , .wr_err(wr_err)
`endif
  );

  // EEPROM model: a cell commits only after the pump ran exactly CHRG cycles
  logic [13:0] mem [4];
  logic        pl_en = 1'b0;
  logic [1:0]  pl_addr = 2'd0;
  logic [13:0] pl_data = 14'd0;
  logic        corrupt = 1'b0;
  int          pcnt = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!eep_cs_n && !eep_r_w_n && !chrg_pmp_en && pcnt == CHRG) mem[eep_addr] <= eep_wr_data;
    if (eep_cs_n) pcnt <= 0;
    else if (chrg_pmp_en) pcnt <= pcnt + 1;
  end

  assign eep_rd_data = mem[eep_addr] ^ {13'd0, corrupt};

  // Reference model state
  logic [13:0] ref_mem [4];
  logic [13:0] exp_rd;
  bit          last_host;
  int          n_checks = 0, n_errors = 0;

  // Observations from the last transaction
  int pg_n, pg_c, pd_n, pd_c, hg_n, hg_c, hd_n, hd_c;
  int cs_lo, cs_first, cs_last, pump_n, pmp_first, pin_bad, busy_n;
  bit obs_to;

  function automatic int op_len(input bit wr);
    return wr ? CHRG + 3 + VFYX : 3;
  endfunction

  function automatic int op_cs(input bit wr);
    return wr ? CHRG + 2 + VFYX : 2;
  endfunction

  task automatic model_op(input bit wr, input logic [1:0] a, input logic [13:0] d);
    if (wr) begin
      ref_mem[a] = d;
      if (VFYX != 0) exp_rd = d;
    end else begin
      exp_rd = ref_mem[a];
    end
  endtask

  task automatic preload();
    logic [13:0] init_v [4];
    init_v[0] = 14'h0111; init_v[1] = 14'h0222; init_v[2] = 14'h1234; init_v[3] = 14'h3FFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 2'(i); pl_data = init_v[i];
      ref_mem[i] = init_v[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives one or two requests and records what the DUT does, cycle 1 = first cycle after the sampling edge
  task automatic run_txn(input bit preq, input logic [1:0] paddr, input bit hreq, input bit hwr,
                         input logic [1:0] haddr, input logic [13:0] hdata);
    int cyc, tail;
    pg_n = 0; pg_c = 0; pd_n = 0; pd_c = 0; hg_n = 0; hg_c = 0; hd_n = 0; hd_c = 0;
    cs_lo = 0; cs_first = 0; cs_last = 0; pump_n = 0; pmp_first = 0; pin_bad = 0; busy_n = 0;
    @(negedge clk);
    pid_req = preq; pid_addr = paddr;
    host_req = hreq; host_wr = hwr; host_addr = haddr; host_wr_data = hdata;
    cyc = 0; tail = 3;
    while (tail > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (pid_gnt === 1'b1)   begin pg_n++; pg_c = cyc; end
      if (pid_done === 1'b1)  begin pd_n++; pd_c = cyc; end
      if (host_gnt === 1'b1)  begin hg_n++; hg_c = cyc; end
      if (host_done === 1'b1) begin hd_n++; hd_c = cyc; end
      if (busy === 1'b1) busy_n++;
      if (eep_cs_n === 1'b0) begin
        cs_lo++;
        if (cs_first == 0) cs_first = cyc;
        cs_last = cyc;
      end
      if (chrg_pmp_en === 1'b1) begin
        pump_n++;
        if (pmp_first == 0) pmp_first = cyc;
        if (eep_wr_data !== hdata || eep_r_w_n !== 1'b0 || eep_cs_n !== 1'b0 || eep_addr !== haddr)
          pin_bad++;
      end
      if (pid_done === 1'b1) pid_req = 1'b0;
      if (host_done === 1'b1) host_req = 1'b0;
      if (!pid_req && !host_req) tail--;
    end
    obs_to = (tail > 0);
    pid_req = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pid_req = 1'b0; host_req = 1'b0; host_wr = 1'b0;
    pid_addr = 2'd0; host_addr = 2'd0; host_wr_data = 14'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (eep_cs_n !== 1'b1) begin n_errors++; $display("FAIL reset_cs_n got %b want 1", eep_cs_n); end
    n_checks++; if (eep_r_w_n !== 1'b1) begin n_errors++; $display("FAIL reset_r_w_n got %b want 1", eep_r_w_n); end
    n_checks++; if (chrg_pmp_en !== 1'b0) begin n_errors++; $display("FAIL reset_pump got %b want 0", chrg_pmp_en); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (rd_data !== 14'd0) begin n_errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_checks++; if (eep_addr !== 2'd0 || eep_wr_data !== 14'd0) begin
      n_errors++; $display("FAIL reset_pins addr %h data %h want 0/0", eep_addr, eep_wr_data); end
    n_checks++; if ({pid_gnt, pid_done, host_gnt, host_done} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_pulses got %b want 0000", {pid_gnt, pid_done, host_gnt, host_done}); end
    rst_n = 1'b1;
    exp_rd = 14'd0; last_host = 1'b0;
  endtask

  task automatic test_pid_read();
    run_txn(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 14'd0);
    model_op(1'b0, 2'd2, 14'd0); last_host = 1'b0;
    n_checks++; if (obs_to) begin n_errors++; $display("FAIL pid_read_timeout"); end
    n_checks++; if (pg_n !== 1 || pg_c !== 1) begin n_errors++; $display("FAIL pid_read_gnt n=%0d cyc=%0d want 1/1", pg_n, pg_c); end
    n_checks++; if (cs_lo !== 2 || cs_first !== 1 || cs_last !== 2) begin
      n_errors++; $display("FAIL pid_read_cs low=%0d %0d..%0d want 2 cycles 1..2", cs_lo, cs_first, cs_last); end
    n_checks++; if (pd_n !== 1 || pd_c !== 3) begin n_errors++; $display("FAIL pid_read_done n=%0d cyc=%0d want 1/3", pd_n, pd_c); end
    n_checks++; if (hd_n !== 0 || hg_n !== 0) begin n_errors++; $display("FAIL pid_read_host_pulse gnt=%0d done=%0d want 0", hg_n, hd_n); end
    n_checks++; if (rd_data !== 14'h1234) begin n_errors++; $display("FAIL pid_read_data got %h want 1234", rd_data); end
    n_checks++; if (busy_n !== 3) begin n_errors++; $display("FAIL pid_read_busy got %0d want 3", busy_n); end
  endtask

  task automatic test_host_write();
    run_txn(1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 14'h0ABC);
    model_op(1'b1, 2'd1, 14'h0ABC); last_host = 1'b1;
    n_checks++; if (obs_to) begin n_errors++; $display("FAIL host_write_timeout"); end
    n_checks++; if (hg_n !== 1 || hg_c !== 1) begin n_errors++; $display("FAIL host_write_gnt n=%0d cyc=%0d want 1/1", hg_n, hg_c); end
    n_checks++; if (pump_n !== CHRG || pmp_first !== 2) begin
      n_errors++; $display("FAIL host_write_pump cycles=%0d first=%0d want %0d/2", pump_n, pmp_first, CHRG); end
    n_checks++; if (pin_bad !== 0) begin n_errors++; $display("FAIL host_write_pins bad=%0d want 0", pin_bad); end
    n_checks++; if (cs_lo !== op_cs(1'b1) || cs_first !== 1) begin
      n_errors++; $display("FAIL host_write_cs low=%0d first=%0d want %0d/1", cs_lo, cs_first, op_cs(1'b1)); end
    n_checks++; if (hd_n !== 1 || hd_c !== op_len(1'b1)) begin
      n_errors++; $display("FAIL host_write_done n=%0d cyc=%0d want 1/%0d", hd_n, hd_c, op_len(1'b1)); end
    n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL host_write_rd_data got %h want %h", rd_data, exp_rd); end
    run_txn(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 14'd0);
    model_op(1'b0, 2'd1, 14'd0); last_host = 1'b0;
    n_checks++; if (obs_to || rd_data !== 14'h0ABC) begin
      n_errors++; $display("FAIL host_write_readback got %h want 0abc to=%0d", rd_data, obs_to); end
  endtask

  task automatic test_round_robin();
    // last owner is PID here, so host wins the tie
    run_txn(1'b1, 2'd0, 1'b1, 1'b0, 2'd3, 14'd0);
    model_op(1'b0, 2'd3, 14'd0); model_op(1'b0, 2'd0, 14'd0); last_host = 1'b0;
    n_checks++; if (obs_to || hg_c !== 1 || hd_c !== 3) begin
      n_errors++; $display("FAIL rr1_host gnt=%0d done=%0d want 1/3", hg_c, hd_c); end
    n_checks++; if (pg_c !== 5 || pd_c !== 7 || pg_n !== 1) begin
      n_errors++; $display("FAIL rr1_pid gnt=%0d done=%0d n=%0d want 5/7/1", pg_c, pd_c, pg_n); end
    n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL rr1_rd_data got %h want %h", rd_data, exp_rd); end
    run_txn(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 14'd0);
    model_op(1'b0, 2'd2, 14'd0); last_host = 1'b1;
    // now host owned last, so PID wins the tie
    run_txn(1'b1, 2'd1, 1'b1, 1'b0, 2'd3, 14'd0);
    model_op(1'b0, 2'd1, 14'd0); model_op(1'b0, 2'd3, 14'd0); last_host = 1'b1;
    n_checks++; if (obs_to || pg_c !== 1 || pd_c !== 3) begin
      n_errors++; $display("FAIL rr2_pid gnt=%0d done=%0d want 1/3", pg_c, pd_c); end
    n_checks++; if (hg_c !== 5 || hd_c !== 7) begin
      n_errors++; $display("FAIL rr2_host gnt=%0d done=%0d want 5/7", hg_c, hd_c); end
  endtask

  task automatic test_reset_mid_write();
    int dn;
    @(negedge clk);
    host_req = 1'b1; host_wr = 1'b1; host_addr = 2'd1; host_wr_data = 14'h2222;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    n_checks++; if (chrg_pmp_en !== 1'b1) begin n_errors++; $display("FAIL abort_pump_before got %b want 1", chrg_pmp_en); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (chrg_pmp_en !== 1'b0 || eep_cs_n !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_pins pump=%b cs_n=%b busy=%b want 0/1/0", chrg_pmp_en, eep_cs_n, busy); end
    host_req = 1'b0; rst_n = 1'b1;
    exp_rd = 14'd0; last_host = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (host_done === 1'b1 || pid_done === 1'b1) dn++;
    end
    n_checks++; if (dn !== 0) begin n_errors++; $display("FAIL abort_done got %0d pulses want 0", dn); end
    run_txn(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 14'd0);
    model_op(1'b0, 2'd1, 14'd0); last_host = 1'b0;
    n_checks++; if (obs_to || pd_c !== 3 || rd_data !== exp_rd) begin
      n_errors++; $display("FAIL abort_then_read done=%0d rd=%h want 3/%h", pd_c, rd_data, exp_rd); end
  endtask

  task automatic test_verify();
    corrupt = 1'b1;
    run_txn(1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 14'h0ABC);
    corrupt = 1'b0;
    model_op(1'b1, 2'd3, 14'h0ABC); last_host = 1'b1;
`ifdef EEP_WR_VERIFY_EN
    exp_rd = 14'h0ABD;
    n_checks++; if (wr_err !== 1'b1) begin n_errors++; $display("FAIL vfy_err_set got %b want 1", wr_err); end
`endif
    n_checks++; if (obs_to || hd_c !== op_len(1'b1)) begin
      n_errors++; $display("FAIL vfy_done_cycle got %0d want %0d", hd_c, op_len(1'b1)); end
    n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL vfy_rd_data got %h want %h", rd_data, exp_rd); end
    run_txn(1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 14'h0ABC);
    model_op(1'b1, 2'd3, 14'h0ABC);
`ifdef EEP_WR_VERIFY_EN
    n_checks++; if (wr_err !== 1'b0) begin n_errors++; $display("FAIL vfy_err_clear got %b want 0", wr_err); end
`endif
    n_checks++; if (obs_to || hd_c !== op_len(1'b1) || rd_data !== exp_rd) begin
      n_errors++; $display("FAIL vfy_second done=%0d rd=%h want %0d/%h", hd_c, rd_data, op_len(1'b1), exp_rd); end
  endtask

  task automatic test_random();
    int mode, lf, ls, e_pg, e_pd, e_hg, e_hd, e_cs;
    bit hp, hh, wr, host_first;
    logic [1:0] pa, ha;
    logic [13:0] hd;
    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 2));
      hp = (mode != 1); hh = (mode != 0);
      wr = 1'($urandom_range(0, 1));
      pa = 2'($urandom); ha = 2'($urandom); hd = 14'($urandom);
      host_first = hh && (!hp || !last_host);
      run_txn(hp, pa, hh, wr, ha, hd);
      lf = host_first ? op_len(wr) : 3;
      ls = (hp && hh) ? (host_first ? 3 : op_len(wr)) : 0;
      e_hg = host_first ? 1 : lf + 2;  e_hd = host_first ? lf : lf + 1 + ls;
      e_pg = host_first ? lf + 2 : 1;  e_pd = host_first ? lf + 1 + ls : lf;
      e_cs = (hp ? 2 : 0) + (hh ? op_cs(wr) : 0);
      if (host_first) begin
        model_op(wr, ha, hd);
        if (hp) model_op(1'b0, pa, 14'd0);
      end else begin
        model_op(1'b0, pa, 14'd0);
        if (hh) model_op(wr, ha, hd);
      end
      last_host = (hp && hh) ? !host_first : hh;
      n_checks++; if (obs_to) begin n_errors++; $display("FAIL rnd%0d_timeout", i); end
      n_checks++; if (pg_n !== int'(hp) || pd_n !== int'(hp) || hg_n !== int'(hh) || hd_n !== int'(hh)) begin
        n_errors++; $display("FAIL rnd%0d_pulses pg=%0d pd=%0d hg=%0d hd=%0d want %0d/%0d", i, pg_n, pd_n, hg_n, hd_n, hp, hh); end
      n_checks++; if (hh && (hg_c !== e_hg || hd_c !== e_hd)) begin
        n_errors++; $display("FAIL rnd%0d_host gnt=%0d done=%0d want %0d/%0d", i, hg_c, hd_c, e_hg, e_hd); end
      n_checks++; if (hp && (pg_c !== e_pg || pd_c !== e_pd)) begin
        n_errors++; $display("FAIL rnd%0d_pid gnt=%0d done=%0d want %0d/%0d", i, pg_c, pd_c, e_pg, e_pd); end
      n_checks++; if (pump_n !== ((hh && wr) ? CHRG : 0) || pin_bad !== 0 || cs_lo !== e_cs) begin
        n_errors++; $display("FAIL rnd%0d_pins pump=%0d bad=%0d cs=%0d want %0d/0/%0d", i, pump_n, pin_bad, cs_lo,
                             (hh && wr) ? CHRG : 0, e_cs); end
      n_checks++; if (busy_n !== lf + ls) begin n_errors++; $display("FAIL rnd%0d_busy got %0d want %0d", i, busy_n, lf + ls); end
      n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL rnd%0d_rd_data got %h want %h", i, rd_data, exp_rd); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_pid_read();
    test_host_write();
    test_round_robin();
    test_reset_mid_write();
    test_verify();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
